// File: rtl/irq_pkg.sv
// Shared types and default parameters for the interrupt controller.
package irq_pkg;

    // Default parameter values used by irq_ctrl and its sub-blocks.
    localparam int DEF_NUM_IRQ    = 8;
    localparam int DEF_VEC_W      = 12;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_EDGE       = 1;
    localparam int DEF_VEC_STRIDE = 4;

    // Presentation FSM: IDLE looks for a candidate, ASSERT holds it until ack.
    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } irq_state_e;

    // Index width for a request vector of n lines (at least one bit).
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage : irq_pkg

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; index 0 wins over every other line.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ,
    parameter int IDX_W   = idx_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/irq_ctrl.sv
// Interrupt controller: request capture, masking, priority selection,
// CPU handshake and a nesting stack tracking the active ISRs.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ    = DEF_NUM_IRQ,
    parameter int VEC_W      = DEF_VEC_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int EDGE       = DEF_EDGE,
    parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irqSrc,
    input  logic                       maskWrEn,
    input  logic [NUM_IRQ-1:0]         maskIn,
    input  logic                       vecBaseWrEn,
    input  logic [VEC_W-1:0]           vecBaseIn,
    output logic                       IRQ,
    output logic [VEC_W-1:0]           IRQn,
    input  logic                       IRQAck,
    input  logic                       irqRet,
    output logic [NUM_IRQ-1:0]         pending,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       retErr
);

    localparam int IDX_W = idx_width(NUM_IRQ);
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int AW    = idx_width(DEPTH);

    // Capture and configuration state
    logic [NUM_IRQ-1:0] hist_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] mask_r;
    logic [VEC_W-1:0]   vec_base_r;
    logic [NUM_IRQ-1:0] set_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] req_s;
    logic [NUM_IRQ-1:0] pending_next_s;

    // Selection / presentation state
    irq_state_e         state_r;
    irq_state_e         state_next_s;
    logic               irq_r;
    logic [VEC_W-1:0]   irqn_r;
    logic [IDX_W-1:0]   sel_r;
    logic [IDX_W-1:0]   cand_s;
    logic               cand_valid_s;
    logic               preempt_ok_s;
    logic               load_s;
    logic               push_s;
    logic [VEC_W-1:0]   vec_addr_s;

    // Nesting stack
    logic [IDX_W-1:0]   stack_r [DEPTH];
    logic [DW-1:0]      depth_r;
    logic [DW-1:0]      depth_pop_s;
    logic [DW-1:0]      depth_next_s;
    logic [IDX_W-1:0]   top_s;
    logic [AW-1:0]      top_ptr_s;
    logic [AW-1:0]      wr_ptr_s;
    logic               pop_s;
    logic               push_ok_s;
    logic               ret_err_r;
    logic               ret_err_set_s;

    // Edge mode looks for a registered 0->1 change; level mode follows the line.
    always_comb begin
        if (EDGE != 0) begin
            set_s = irqSrc & ~hist_r;
        end else begin
            set_s = irqSrc;
        end
    end

    // Acceptance clears the selected bit; a new capture in the same cycle wins.
    always_comb begin
        clr_s = {NUM_IRQ{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_s[i] = push_s && (sel_r == IDX_W'(i));
        end
        pending_next_s = (pending_r & ~clr_s) | set_s;
        req_s          = pending_r & mask_r;
    end

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (req_s),
        .idx   (cand_s),
        .valid (cand_valid_s)
    );

    // Stack top and the nesting rule: empty stack, or strictly higher
    // priority than the running ISR with a free level left.
    always_comb begin
        top_ptr_s = AW'(depth_r - DW'(1));
        top_s     = stack_r[top_ptr_s];
        if (depth_r == DW'(0)) begin
            preempt_ok_s = 1'b1;
        end else if ((cand_s < top_s) && (depth_r < DW'(DEPTH))) begin
            preempt_ok_s = 1'b1;
        end else begin
            preempt_ok_s = 1'b0;
        end
        vec_addr_s = vec_base_r + (VEC_W'(cand_s) * VEC_W'(VEC_STRIDE));
    end

    // Next-state logic: present a candidate once, hold it until the CPU acks.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cand_valid_s && preempt_ok_s) begin
                    state_next_s = ASSERT;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ASSERT: begin
                if (IRQAck) begin
                    state_next_s = IDLE;
                    push_s       = 1'b1;
                end else begin
                    state_next_s = ASSERT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Return handling: pop first, then push, so ret+ack swaps the top in place.
    always_comb begin
        pop_s         = irqRet && (depth_r != DW'(0));
        ret_err_set_s = irqRet && (depth_r == DW'(0));
        if (pop_s) begin
            depth_pop_s = depth_r - DW'(1);
        end else begin
            depth_pop_s = depth_r;
        end
        push_ok_s = push_s && (depth_pop_s < DW'(DEPTH));
        wr_ptr_s  = AW'(depth_pop_s);
        if (push_ok_s) begin
            depth_next_s = depth_pop_s + DW'(1);
        end else begin
            depth_next_s = depth_pop_s;
        end
    end

    // Request capture, pending bits and software-written configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r     <= {NUM_IRQ{1'b1}};
            pending_r  <= {NUM_IRQ{1'b0}};
            mask_r     <= {NUM_IRQ{1'b0}};
            vec_base_r <= {VEC_W{1'b0}};
        end else begin
            hist_r    <= irqSrc;
            pending_r <= pending_next_s;
            if (maskWrEn) begin
                mask_r <= maskIn;
            end else begin
                mask_r <= mask_r;
            end
            if (vecBaseWrEn) begin
                vec_base_r <= vecBaseIn;
            end else begin
                vec_base_r <= vec_base_r;
            end
        end
    end

    // FSM state plus the registered IRQ/IRQn/sel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            irq_r   <= 1'b0;
            irqn_r  <= {VEC_W{1'b0}};
            sel_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            irq_r   <= (state_next_s == ASSERT);
            if (load_s) begin
                irqn_r <= vec_addr_s;
                sel_r  <= cand_s;
            end else begin
                irqn_r <= irqn_r;
                sel_r  <= sel_r;
            end
        end
    end

    // Nesting stack entries and the depth pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_r <= {DW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            depth_r <= depth_next_s;
            if (push_ok_s) begin
                stack_r[wr_ptr_s] <= sel_r;
            end else begin
                stack_r[wr_ptr_s] <= stack_r[wr_ptr_s];
            end
        end
    end

    // Sticky error for a return with nothing on the stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_err_r <= 1'b0;
        end else if (ret_err_set_s) begin
            ret_err_r <= 1'b1;
        end else begin
            ret_err_r <= ret_err_r;
        end
    end

    assign IRQ     = irq_r;
    assign IRQn    = irqn_r;
    assign pending = pending_r;
    assign depth   = depth_r;
    assign retErr  = ret_err_r;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: reference model + scoreboard queue,
// directed scenarios followed by randomized traffic.
module tb_irq_ctrl;

    localparam int N   = 8;
    localparam int VW  = 12;
    localparam int D   = 4;
    localparam int STR = 4;
    localparam int DW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irqSrc;
    logic          maskWrEn;
    logic [N-1:0]  maskIn;
    logic          vecBaseWrEn;
    logic [VW-1:0] vecBaseIn;
    logic          IRQAck;
    logic          irqRet;

    logic          IRQ,    l_IRQ;
    logic [VW-1:0] IRQn,   l_IRQn;
    logic [N-1:0]  pending, l_pending;
    logic [DW-1:0] depth,  l_depth;
    logic          retErr, l_retErr;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(N), .VEC_W(VW), .DEPTH(D), .EDGE(1), .VEC_STRIDE(STR)) dut (
        .clk(clk), .rst(rst), .irqSrc(irqSrc), .maskWrEn(maskWrEn), .maskIn(maskIn),
        .vecBaseWrEn(vecBaseWrEn), .vecBaseIn(vecBaseIn), .IRQ(IRQ), .IRQn(IRQn),
        .IRQAck(IRQAck), .irqRet(irqRet), .pending(pending), .depth(depth), .retErr(retErr)
    );

    irq_ctrl #(.NUM_IRQ(N), .VEC_W(VW), .DEPTH(D), .EDGE(0), .VEC_STRIDE(STR)) dut_lvl (
        .clk(clk), .rst(rst), .irqSrc(irqSrc), .maskWrEn(maskWrEn), .maskIn(maskIn),
        .vecBaseWrEn(vecBaseWrEn), .vecBaseIn(vecBaseIn), .IRQ(l_IRQ), .IRQn(l_IRQn),
        .IRQAck(IRQAck), .irqRet(irqRet), .pending(l_pending), .depth(l_depth), .retErr(l_retErr)
    );

    typedef struct {
        logic          irq;
        logic [VW-1:0] irqn;
        logic [N-1:0]  pend;
        int            dep;
        logic          rerr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model (edge-mode instance): behavioural, queue-based stack.
    bit [N-1:0] m_pend  = '0;
    bit [N-1:0] m_mask  = '0;
    bit [N-1:0] m_hist  = '1;
    int         m_vbase = 0;
    int         m_stk[$];
    int         m_pres  = -1;
    int         m_irqn  = 0;
    bit         m_rerr  = 1'b0;

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        exp_t       e;
        bit [N-1:0] setv;
        bit [N-1:0] clr;
        int         cand;
        bit         allow;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_hist = '1; m_vbase = 0;
            m_stk.delete(); m_pres = -1; m_irqn = 0; m_rerr = 1'b0;
        end else begin
            setv   = irqSrc & ~m_hist;
            m_hist = irqSrc;
            cand   = lowest(m_pend & m_mask);
            if (m_stk.size() == 0) allow = 1'b1;
            else allow = (cand < m_stk[m_stk.size()-1]) && (m_stk.size() < D);
            clr = '0;
            if (irqRet) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_rerr = 1'b1;
            end
            if (m_pres >= 0) begin
                if (IRQAck) begin
                    clr[m_pres] = 1'b1;
                    m_stk.push_back(m_pres);
                    m_pres = -1;
                end
            end else if (cand >= 0 && allow) begin
                m_pres = cand;
                m_irqn = (m_vbase + cand * STR) % (1 << VW);
            end
            m_pend = (m_pend & ~clr) | setv;
            if (maskWrEn) m_mask = maskIn;
            if (vecBaseWrEn) m_vbase = int'(vecBaseIn);
        end
        e.irq  = (m_pres >= 0);
        e.irqn = VW'(m_irqn);
        e.pend = m_pend;
        e.dep  = m_stk.size();
        e.rerr = m_rerr;
        exp_q.push_back(e);
    endtask

    // One cycle: record the expectation, then move to the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic clr_pulses();
        maskWrEn = 1'b0; vecBaseWrEn = 1'b0; IRQAck = 1'b0; irqRet = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic fire_ack(input int i);
        irqSrc[i] = 1'b1; tick(); irqSrc[i] = 1'b0;
        tick(); tick();
        chk("fire_irq", 32'(IRQ), 32'd1);
        chk("fire_irqn", 32'(IRQn), 32'(12'h100 + 4 * i));
        IRQAck = 1'b1; tick(); IRQAck = 1'b0;
    endtask

    // Scoreboard monitor: compare every registered output after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (IRQ !== e.irq) begin
                    miscompares++;
                    $display("FAIL sb_irq: got %0b expected %0b at %0t", IRQ, e.irq, $time);
                end
                if (e.irq && (IRQn !== e.irqn)) begin
                    miscompares++;
                    $display("FAIL sb_irqn: got 0x%0h expected 0x%0h at %0t", IRQn, e.irqn, $time);
                end
                if (pending !== e.pend) begin
                    miscompares++;
                    $display("FAIL sb_pending: got 0x%0h expected 0x%0h at %0t", pending, e.pend, $time);
                end
                if (depth !== DW'(e.dep)) begin
                    miscompares++;
                    $display("FAIL sb_depth: got %0d expected %0d at %0t", depth, e.dep, $time);
                end
                if (retErr !== e.rerr) begin
                    miscompares++;
                    $display("FAIL sb_retErr: got %0b expected %0b at %0t", retErr, e.rerr, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; irqSrc = '1; maskIn = '0; vecBaseIn = '0;
        clr_pulses();
        @(negedge clk);
        repeat (3) tick();
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);

        // Lines held high through reset release: edge sees nothing, level fires.
        rst = 1'b0; maskWrEn = 1'b1; maskIn = 8'hFF;
        tick(); clr_pulses();
        chk("lvl_pend_r1", 32'(l_pending), 32'hFF);
        chk("lvl_irq_r1", 32'(l_IRQ), 32'd0);
        tick();
        chk("lvl_irq_r2", 32'(l_IRQ), 32'd1);
        chk("lvl_irqn_r2", 32'(l_IRQn), 32'd0);
        chk("edge_pend_r2", 32'(pending), 32'd0);
        repeat (3) tick();
        chk("edge_irq_held", 32'(IRQ), 32'd0);
        rst = 1'b1; irqSrc = '0;
        tick(); tick();
        rst = 1'b0;

        // Basic latency and acceptance.
        maskWrEn = 1'b1; maskIn = 8'hFF; vecBaseWrEn = 1'b1; vecBaseIn = 12'h100;
        tick(); clr_pulses();
        irqSrc[3] = 1'b1; tick(); irqSrc[3] = 1'b0;
        chk("lat_pend3", 32'(pending[3]), 32'd1);
        chk("lat_irq_n1", 32'(IRQ), 32'd0);
        tick();
        chk("lat_irq_n2", 32'(IRQ), 32'd1);
        chk("lat_irqn", 32'(IRQn), 32'h10C);
        tick(); tick();
        IRQAck = 1'b1; tick(); IRQAck = 1'b0;
        chk("ack_irq", 32'(IRQ), 32'd0);
        chk("ack_pend3", 32'(pending[3]), 32'd0);
        chk("ack_depth", 32'(depth), 32'd1);

        // Nesting: 5 blocked behind 3, 1 preempts.
        irqSrc[5] = 1'b1; tick(); irqSrc[5] = 1'b0;
        tick(); tick();
        chk("nest_no5", 32'(IRQ), 32'd0);
        irqSrc[1] = 1'b1; tick(); irqSrc[1] = 1'b0;
        tick(); tick();
        chk("nest_irq1", 32'(IRQ), 32'd1);
        chk("nest_irqn1", 32'(IRQn), 32'h104);
        IRQAck = 1'b1; tick(); IRQAck = 1'b0;
        chk("nest_depth2", 32'(depth), 32'd2);
        chk("nest_pend5", 32'(pending[5]), 32'd1);
        irqRet = 1'b1; tick(); irqRet = 1'b0;
        tick(); tick();
        chk("nest_still_no5", 32'(IRQ), 32'd0);
        irqRet = 1'b1; tick(); irqRet = 1'b0;
        tick();
        chk("nest_irqn5", 32'(IRQn), 32'h114);
        IRQAck = 1'b1; tick(); IRQAck = 1'b0;
        irqRet = 1'b1; tick(); irqRet = 1'b0;

        // Full stack holds off index 0 until a level is freed.
        for (int i = 7; i >= 4; i--) fire_ack(i);
        chk("full_depth", 32'(depth), 32'd4);
        irqSrc[0] = 1'b1; tick(); irqSrc[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("full_no_irq", 32'(IRQ), 32'd0);
        end
        irqRet = 1'b1; tick(); irqRet = 1'b0;
        chk("full_ret_n1", 32'(IRQ), 32'd0);
        tick();
        chk("full_ret_irq", 32'(IRQ), 32'd1);
        chk("full_ret_irqn", 32'(IRQn), 32'h100);
        IRQAck = 1'b1; tick(); IRQAck = 1'b0;
        for (int k = 0; k < 4; k++) begin
            irqRet = 1'b1; tick(); irqRet = 1'b0;
        end
        chk("full_empty", 32'(depth), 32'd0);

        // Return errors and simultaneous ret+ack.
        irqRet = 1'b1; tick(); irqRet = 1'b0;
        chk("reterr_flag", 32'(retErr), 32'd1);
        chk("reterr_depth", 32'(depth), 32'd0);
        fire_ack(4);
        fire_ack(2);
        irqSrc[1] = 1'b1; tick(); irqSrc[1] = 1'b0;
        tick(); tick();
        IRQAck = 1'b1; irqRet = 1'b1; tick(); clr_pulses();
        chk("swap_depth", 32'(depth), 32'd2);
        chk("swap_irq", 32'(IRQ), 32'd0);
        irqRet = 1'b1; tick(); tick(); irqRet = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            irqSrc      = N'($urandom) & N'($urandom) & N'($urandom);
            maskWrEn    = ($urandom_range(0, 19) == 0);
            maskIn      = N'($urandom) | N'($urandom);
            vecBaseWrEn = ($urandom_range(0, 49) == 0);
            vecBaseIn   = VW'($urandom);
            IRQAck      = (m_pres >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            irqRet      = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; irqSrc = '0; clr_pulses();
        repeat (3) tick();
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_irq_ctrl

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_IRQ, default 8, number of request channels (2..32); VEC_W, default 12, vector width, matching the instruction address width; DEPTH, default 4, nesting stack depth; EDGE, default 1, 1 for edge-capture and 0 for level-capture; VEC_STRIDE, default 4, address spacing between vectors.
REQ-002 clk  in  1  sole clock; all state changes on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 irqSrc  in  NUM_IRQ  raw request lines; index 0 is highest priority.
REQ-005 maskWrEn / maskIn  in  1 / NUM_IRQ  enable-mask write; 1 means enabled.
REQ-006 vecBaseWrEn / vecBaseIn  in  1 / VEC_W  vector base write.
REQ-007 IRQ  out  1  interrupt request to the CPU.
REQ-008 IRQn  out  VEC_W  vector address presented with IRQ.
REQ-009 IRQAck  in  1  CPU has taken the vector.
REQ-010 irqRet  in  1  CPU has finished the current ISR (one-cycle pulse).
REQ-011 pending  out  NUM_IRQ  latched pending bits.
REQ-012 depth  out  clog2(DEPTH+1)  current nesting level.
REQ-013 retErr  out  1  sticky flag for irqRet received with an empty stack.

Function
REQ-014 Capture in edge mode SHALL set pending[i] on a registered 0->1 transition of irqSrc[i].
REQ-015 Capture in level mode SHALL set pending[i] in every cycle irqSrc[i] is high.
REQ-016 pending[i] SHALL clear only on acceptance (IRQAck) of index i; a same-cycle set and clear SHALL leave the bit set.
REQ-017 Masking SHALL NOT clear pending; mask and vecBase writes SHALL take effect the following cycle.
REQ-018 The candidate SHALL be the lowest index in (pending & mask), resolved combinationally each cycle.
REQ-019 Preemption SHALL be allowed only when the stack is empty, or when the candidate index is strictly lower than the stack-top index and depth < DEPTH.
REQ-020 The FSM SHALL have states IDLE and ASSERT.
- IDLE -> ASSERT when a candidate exists and preemption is allowed.
- On that transition, register sel and drive IRQ=1, IRQn = vecBase + sel*VEC_STRIDE (modulo 2^VEC_W).
REQ-021 In ASSERT, IRQ and IRQn SHALL hold stable until IRQAck=1; no retargeting occurs, even for a higher-priority arrival or source withdrawal.
REQ-022 IRQAck in ASSERT SHALL, in a single cycle: push sel, clear pending[sel], drop IRQ, and return the FSM to IDLE.
REQ-023 IRQAck in IDLE SHALL be ignored.
REQ-024 irqRet SHALL pop the stack top; irqRet with an empty stack SHALL leave state unchanged and set retErr.
REQ-025 When irqRet and IRQAck occur in the same cycle, the pop SHALL be applied before the push, leaving depth unchanged and the new top equal to sel.
REQ-026 Latency: a source edge at cycle N SHALL give pending=1 at N+1 and IRQ=1 at N+2 (IDLE, unmasked, preemption allowed).
REQ-027 After acceptance, the next IRQ SHALL NOT assert earlier than the cycle following the IRQAck cycle.
REQ-028 When the stack is full, requests SHALL remain pending until an irqRet frees a level.

Reset
REQ-029 While rst=1, the block SHALL clear IRQ, IRQn, pending, depth, retErr, mask and vecBase, empty the stack, and set the FSM to IDLE.
REQ-030 The edge-detect history register SHALL reset to all-ones, so that lines already high at reset exit do not register as edges.
REQ-031 Reset asserted during ASSERT SHALL abort the request, dropping IRQ the next cycle, with no push.

Structure
REQ-032 Package irq_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 Sub-module irq_prio_enc, parametrised by NUM_IRQ, SHALL provide a lowest-index-first encoder with a valid output.
REQ-034 The stack SHALL be a DEPTH-entry register array with a pointer; no memory macro.

Verification
REQ-035 Mask=0xFF, vecBase=0x100; pulse irqSrc[3] at cycle 10 -> pending[3] at 11, IRQ=1 with IRQn=0x10C at 12; IRQAck at 14 -> IRQ=0, pending[3]=0, depth=1.
REQ-036 While ISR 3 is active (depth 1), edge irqSrc[5] then irqSrc[1] -> only 1 is presented, IRQn=0x104, depth=2; 5 remains pending until two irqRet pulses.
REQ-037 DEPTH=4, fire 7,6,5,4 in turn, acking each, then fire 0 -> no IRQ until one irqRet, then IRQn=0x100 after 2 cycles.
REQ-038 irqRet with depth=0 -> retErr=1, depth stays 0; irqRet and IRQAck in the same cycle at depth 2 -> depth stays 2.
REQ-039 With irqSrc held high through reset release in edge mode -> no IRQ; in level mode (EDGE=0) -> IRQ at the 2nd cycle after release.
